issue_queue_mult: RTL and testbench

//  Reservation station and issue stage that feeds the pipelined multiplier unit.

---
 rtl/issue_queue_mult_pkg.sv | 24 ++
 rtl/issue_queue_mult_if.sv | 63 ++++++
 rtl/issue_queue_mult_mult_latency_tracker.sv | 57 +++++
 rtl/issue_queue_mult.sv | 185 ++++++++++++++++++
 tb/tb_issue_queue_mult.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_mult_pkg.sv
// ---------------------------------------------------------------------------
// issue_queue_mult_pkg
//   Shared defaults and width helpers for the MULT reservation station.
//   Contents:
//     IQ_DEPTH, IQ_DATA_W, IQ_TAG_W, IQ_MULT_LAT : default parameter values
//     iq_cnt_w(depth) : width of an occupancy counter covering 0..depth
//     iq_idx_w(depth) : width of an entry index covering 0..depth-1
// ---------------------------------------------------------------------------
package issue_queue_mult_pkg;

  localparam int unsigned IQ_DEPTH    = 4;
  localparam int unsigned IQ_DATA_W   = 32;
  localparam int unsigned IQ_TAG_W    = 6;
  localparam int unsigned IQ_MULT_LAT = 4;

  function automatic int unsigned iq_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned iq_idx_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/issue_queue_mult_if.sv
// ---------------------------------------------------------------------------
// issue_queue_mult_if
//   Bus bundle between the rename/dispatch stage, the CDB, and the MULT
//   issue queue.
//   Signals:
//     flush                       : mispredict flush
//     dispatch_*                  : one op written per cycle when enabled
//     issueque_full               : queue occupancy == DEPTH
//     cdb_valid/tag/data          : result broadcast used for operand wakeup
//     issuemult_*                 : registered issue to the multiplier
//     mult_done_valid/rdtag       : product-valid strobe and its tag
//   Modports:
//     master : environment side (drives dispatch, CDB, flush)
//     slave  : issue queue side
// ---------------------------------------------------------------------------
interface issue_queue_mult_if
  import issue_queue_mult_pkg::*;
#(
  parameter int unsigned DATA_W = IQ_DATA_W,
  parameter int unsigned TAG_W  = IQ_TAG_W
);

  logic              flush;
  logic              dispatch_enable;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic              dispatch_rsvalid;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic              dispatch_rtvalid;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic              issueque_full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issuemult_enable;
  logic [DATA_W-1:0] issuemult_rsdata;
  logic [DATA_W-1:0] issuemult_rtdata;
  logic [TAG_W-1:0]  issuemult_rdtag;
  logic              mult_done_valid;
  logic [TAG_W-1:0]  mult_done_rdtag;

  modport master (
    output flush,
    output dispatch_enable, dispatch_rsdata, dispatch_rsvalid, dispatch_rstag,
    output dispatch_rtdata, dispatch_rtvalid, dispatch_rttag, dispatch_rdtag,
    output cdb_valid, cdb_tag, cdb_data,
    input  issueque_full,
    input  issuemult_enable, issuemult_rsdata, issuemult_rtdata, issuemult_rdtag,
    input  mult_done_valid, mult_done_rdtag
  );

  modport slave (
    input  flush,
    input  dispatch_enable, dispatch_rsdata, dispatch_rsvalid, dispatch_rstag,
    input  dispatch_rtdata, dispatch_rtvalid, dispatch_rttag, dispatch_rdtag,
    input  cdb_valid, cdb_tag, cdb_data,
    output issueque_full,
    output issuemult_enable, issuemult_rsdata, issuemult_rtdata, issuemult_rdtag,
    output mult_done_valid, mult_done_rdtag
  );

endinterface

// File: rtl/issue_queue_mult_mult_latency_tracker.sv
// ---------------------------------------------------------------------------
// mult_latency_tracker
//   Shadows the pipelined multiplier with a MULT_LAT-deep {valid,tag} shift
//   register so the destination tag emerges in the same cycle as the product.
//   Ports:
//     clk, reset     : clock, synchronous active-low reset
//     flush_i        : invalidates every stage (products in flight are dropped)
//     in_valid_i     : issue strobe entering stage 0
//     in_tag_i       : destination tag entering stage 0
//     done_valid_o   : last-stage valid
//     done_tag_o     : last-stage tag
// ---------------------------------------------------------------------------
module mult_latency_tracker
  import issue_queue_mult_pkg::*;
#(
  parameter int unsigned MULT_LAT = IQ_MULT_LAT,
  parameter int unsigned TAG_W    = IQ_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             done_valid_o,
  output logic [TAG_W-1:0] done_tag_o
);

  logic [MULT_LAT-1:0] vld_q;
  logic [TAG_W-1:0]    tag_q [MULT_LAT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      // Tags keep shifting during flush; only the valids matter downstream.
      tag_q[0] <= in_tag_i;
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (flush_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid_i;
        for (int unsigned i = 1; i < MULT_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end
  end

  assign done_valid_o = vld_q[MULT_LAT-1];
  assign done_tag_o   = tag_q[MULT_LAT-1];

endmodule

// File: rtl/issue_queue_mult.sv
// ---------------------------------------------------------------------------
// issue_queue_mult
//   Reservation station + issue stage for the pipelined multiplier.
//   Holds dispatched MULT ops in a collapsing queue (entry 0 oldest), wakes
//   waiting operands from CDB broadcasts, issues the oldest ready op (one per
//   cycle) into registered issuemult_* outputs, and delays the destination
//   tag by MULT_LAT so it lines up with the product.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-low reset
//     bus   : issue_queue_mult_if.slave (dispatch, CDB, flush, issue, done)
// ---------------------------------------------------------------------------
module issue_queue_mult
  import issue_queue_mult_pkg::*;
#(
  parameter int unsigned DEPTH    = IQ_DEPTH,
  parameter int unsigned DATA_W   = IQ_DATA_W,
  parameter int unsigned TAG_W    = IQ_TAG_W,
  parameter int unsigned MULT_LAT = IQ_MULT_LAT
) (
  input logic               clk,
  input logic               reset,
  issue_queue_mult_if.slave bus
);

  localparam int unsigned CNT_W = iq_cnt_w(DEPTH);
  localparam int unsigned IDX_W = iq_idx_w(DEPTH);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  tag;
  } opnd_t;

  typedef struct packed {
    logic             valid;
    opnd_t            rs;
    opnd_t            rt;
    logic [TAG_W-1:0] rd;
  } entry_t;

  // Operand capture: only a still-waiting operand of a live entry may match.
  function automatic opnd_t wake_op(
    input opnd_t             op,
    input logic              live,
    input logic              cv,
    input logic [TAG_W-1:0]  ct,
    input logic [DATA_W-1:0] cd
  );
    opnd_t r;
    r = op;
    if (live && !op.vld && cv && (ct == op.tag)) begin
      r.vld = 1'b1;
      r.d   = cd;
    end
    return r;
  endfunction

  entry_t            ent_q     [DEPTH];
  entry_t            ent_d     [DEPTH];
  entry_t            woken_ext [DEPTH+1];
  entry_t            new_ent;
  entry_t            sel_ent;
  logic [CNT_W-1:0]  count_q, count_d, wr_cnt;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_ready;
  logic              full;
  logic              accept;

  logic              iss_en_q;
  logic [DATA_W-1:0] iss_rs_q, iss_rt_q;
  logic [TAG_W-1:0]  iss_rd_q;
  logic              done_valid;
  logic [TAG_W-1:0]  done_tag;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign accept = bus.dispatch_enable && !full;

  // Wakeup of resident entries. The extra trailing slot is always empty and
  // feeds the top entry when the queue collapses.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken_ext[i]    = ent_q[i];
      woken_ext[i].rs = wake_op(ent_q[i].rs, ent_q[i].valid,
                                bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      woken_ext[i].rt = wake_op(ent_q[i].rt, ent_q[i].valid,
                                bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    woken_ext[DEPTH] = '0;
  end

  // Incoming op, with same-cycle CDB capture.
  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.rs.vld = bus.dispatch_rsvalid;
    new_ent.rs.d   = bus.dispatch_rsdata;
    new_ent.rs.tag = bus.dispatch_rstag;
    new_ent.rt.vld = bus.dispatch_rtvalid;
    new_ent.rt.d   = bus.dispatch_rtdata;
    new_ent.rt.tag = bus.dispatch_rttag;
    new_ent.rd     = bus.dispatch_rdtag;
    new_ent.rs     = wake_op(new_ent.rs, 1'b1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    new_ent.rt     = wake_op(new_ent.rt, 1'b1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Oldest-first select on pre-edge state (no wakeup bypass).
  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    sel_ent   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!any_ready && ent_q[i].valid && ent_q[i].rs.vld && ent_q[i].rt.vld) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_ent   = ent_q[i];
      end
    end
  end

  // Collapse above the winner, then drop the new op into the first free slot
  // of the already-collapsed queue.
  always_comb begin
    wr_cnt  = count_q - CNT_W'(any_ready);
    count_d = wr_cnt + CNT_W'(accept);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = (any_ready && (IDX_W'(i) >= sel_idx)) ? woken_ext[i+1] : woken_ext[i];
      if (accept && (wr_cnt == CNT_W'(i))) begin
        ent_d[i] = new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      iss_en_q <= 1'b0;
      iss_rs_q <= '0;
      iss_rt_q <= '0;
      iss_rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else if (bus.flush) begin
      count_q  <= '0;
      iss_en_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      iss_en_q <= any_ready;
      if (any_ready) begin
        iss_rs_q <= sel_ent.rs.d;
        iss_rt_q <= sel_ent.rt.d;
        iss_rd_q <= sel_ent.rd;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  mult_latency_tracker #(
    .MULT_LAT (MULT_LAT),
    .TAG_W    (TAG_W)
  ) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (bus.flush),
    .in_valid_i   (iss_en_q),
    .in_tag_i     (iss_rd_q),
    .done_valid_o (done_valid),
    .done_tag_o   (done_tag)
  );

  assign bus.issueque_full    = full;
  assign bus.issuemult_enable = iss_en_q;
  assign bus.issuemult_rsdata = iss_rs_q;
  assign bus.issuemult_rtdata = iss_rt_q;
  assign bus.issuemult_rdtag  = iss_rd_q;
  assign bus.mult_done_valid  = done_valid;
  assign bus.mult_done_rdtag  = done_tag;

endmodule

// File: tb/tb_issue_queue_mult.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_mult
//   Self-checking bench for issue_queue_mult: a queue-based reference model
//   updated on every rising edge, a compare process on every falling edge,
//   directed scenarios with literal expectations, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_issue_queue_mult;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned MULT_LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  issue_queue_mult_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  issue_queue_mult #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .TAG_W    (TAG_W),
    .MULT_LAT (MULT_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic              rs_v;
    logic [DATA_W-1:0] rs_d;
    logic [TAG_W-1:0]  rs_t;
    logic              rt_v;
    logic [DATA_W-1:0] rt_d;
    logic [TAG_W-1:0]  rt_t;
    logic [TAG_W-1:0]  rd;
  } op_t;

  typedef struct {
    int unsigned      due;
    logic [TAG_W-1:0] tag;
  } ev_t;

  op_t               q[$];
  ev_t               evs[$];
  logic              m_en = 1'b0;
  logic [DATA_W-1:0] m_rs = '0, m_rt = '0;
  logic [TAG_W-1:0]  m_rd = '0;
  bit                live = 1'b0;
  int unsigned       cyc = 0;
  bit                m_full;
  int                m_sel;
  op_t               nw, tmp;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      q.delete(); evs.delete();
      m_en = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0;
      live = 1'b1;
    end else if (bus.flush) begin
      q.delete(); evs.delete();
      m_en = 1'b0;
    end else begin
      m_full = (q.size() == DEPTH);
      m_sel  = -1;
      for (int i = 0; i < q.size(); i++)
        if (m_sel < 0 && q[i].rs_v && q[i].rt_v) m_sel = i;
      m_en = (m_sel >= 0);
      if (m_en) begin
        m_rs = q[m_sel].rs_d; m_rt = q[m_sel].rt_d; m_rd = q[m_sel].rd;
        q.delete(m_sel);
        evs.push_back('{due: cyc + MULT_LAT, tag: m_rd});
      end
      if (bus.cdb_valid) begin
        for (int i = 0; i < q.size(); i++) begin
          tmp = q[i];
          if (!tmp.rs_v && tmp.rs_t == bus.cdb_tag) begin tmp.rs_v = 1'b1; tmp.rs_d = bus.cdb_data; end
          if (!tmp.rt_v && tmp.rt_t == bus.cdb_tag) begin tmp.rt_v = 1'b1; tmp.rt_d = bus.cdb_data; end
          q[i] = tmp;
        end
      end
      if (bus.dispatch_enable && !m_full) begin
        nw.rs_v = bus.dispatch_rsvalid; nw.rs_d = bus.dispatch_rsdata; nw.rs_t = bus.dispatch_rstag;
        nw.rt_v = bus.dispatch_rtvalid; nw.rt_d = bus.dispatch_rtdata; nw.rt_t = bus.dispatch_rttag;
        nw.rd   = bus.dispatch_rdtag;
        if (bus.cdb_valid && !nw.rs_v && nw.rs_t == bus.cdb_tag) begin nw.rs_v = 1'b1; nw.rs_d = bus.cdb_data; end
        if (bus.cdb_valid && !nw.rt_v && nw.rt_t == bus.cdb_tag) begin nw.rt_v = 1'b1; nw.rt_d = bus.cdb_data; end
        q.push_back(nw);
      end
    end
    while (evs.size() > 0 && evs[0].due < cyc) void'(evs.pop_front());
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (live) begin
      chk("m_enable", bus.issuemult_enable, m_en);
      chk("m_rsdata", bus.issuemult_rsdata, m_rs);
      chk("m_rtdata", bus.issuemult_rtdata, m_rt);
      chk("m_rdtag",  bus.issuemult_rdtag,  m_rd);
      chk("m_full",   bus.issueque_full,    q.size() == DEPTH);
      if (evs.size() > 0 && evs[0].due == cyc) begin
        chk("m_done_valid", bus.mult_done_valid, 1'b1);
        chk("m_done_tag",   bus.mult_done_rdtag, evs[0].tag);
      end else begin
        chk("m_done_valid", bus.mult_done_valid, 1'b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    bus.dispatch_enable = 1'b0;
    bus.dispatch_rsdata = '0; bus.dispatch_rsvalid = 1'b0; bus.dispatch_rstag = '0;
    bus.dispatch_rtdata = '0; bus.dispatch_rtvalid = 1'b0; bus.dispatch_rttag = '0;
    bus.dispatch_rdtag = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
  endtask

  task automatic disp(input logic rsv, input logic [DATA_W-1:0] rsd, input logic [TAG_W-1:0] rst,
                      input logic rtv, input logic [DATA_W-1:0] rtd, input logic [TAG_W-1:0] rtt,
                      input logic [TAG_W-1:0] rd);
    bus.dispatch_enable = 1'b1;
    bus.dispatch_rsvalid = rsv; bus.dispatch_rsdata = rsd; bus.dispatch_rstag = rst;
    bus.dispatch_rtvalid = rtv; bus.dispatch_rtdata = rtd; bus.dispatch_rttag = rtt;
    bus.dispatch_rdtag = rd;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  task automatic drain();
    idle();
    repeat (MULT_LAT + 2) step();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) step();
    chk("rst_enable", bus.issuemult_enable, 1'b0);
    chk("rst_full",   bus.issueque_full, 1'b0);
    chk("rst_done",   bus.mult_done_valid, 1'b0);
    reset = 1'b1;

    // 1: both operands ready, issue next edge, done MULT_LAT later
    disp(1'b1, 7, 0, 1'b1, 6, 0, 6'h05);
    step(); idle();
    chk("t1_no_issue_yet", bus.issuemult_enable, 1'b0);
    step();
    chk("t1_enable", bus.issuemult_enable, 1'b1);
    chk("t1_rs", bus.issuemult_rsdata, 7);
    chk("t1_rt", bus.issuemult_rtdata, 6);
    chk("t1_rd", bus.issuemult_rdtag, 6'h05);
    repeat (MULT_LAT - 1) step();
    chk("t1_done_early", bus.mult_done_valid, 1'b0);
    step();
    chk("t1_done", bus.mult_done_valid, 1'b1);
    chk("t1_done_tag", bus.mult_done_rdtag, 6'h05);
    step();
    chk("t1_done_single", bus.mult_done_valid, 1'b0);
    drain();

    // 2: rt woken by CDB two cycles after dispatch
    disp(1'b1, 2, 0, 1'b0, 0, 6'h12, 6'h21);
    step(); idle();
    chk("t2_wait_a", bus.issuemult_enable, 1'b0);
    step();
    chk("t2_wait_b", bus.issuemult_enable, 1'b0);
    cdb(6'h12, 3);
    step(); idle();
    chk("t2_no_bypass", bus.issuemult_enable, 1'b0);
    step();
    chk("t2_enable", bus.issuemult_enable, 1'b1);
    chk("t2_rt", bus.issuemult_rtdata, 3);
    chk("t2_rs", bus.issuemult_rsdata, 2);
    chk("t2_rd", bus.issuemult_rdtag, 6'h21);
    drain();

    // 3: CDB match in the dispatch cycle
    disp(1'b1, 1, 0, 1'b0, 0, 6'h09, 6'h31);
    cdb(6'h09, 32'hA);
    step(); idle();
    chk("t3_wait", bus.issuemult_enable, 1'b0);
    step();
    chk("t3_enable", bus.issuemult_enable, 1'b1);
    chk("t3_rt", bus.issuemult_rtdata, 32'hA);
    drain();

    // 4: fill, then a dispatch while full is dropped despite a same-cycle issue
    for (int k = 0; k < 4; k++) begin
      disp(1'b0, 0, 6'(8'h30 + k), 1'b1, 32'(k + 1), 0, 6'(8'h20 + k));
      step();
    end
    idle();
    chk("t4_full", bus.issueque_full, 1'b1);
    cdb(6'h30, 32'h55);
    step(); idle();
    chk("t4_still_full", bus.issueque_full, 1'b1);
    disp(1'b1, 9, 0, 1'b1, 9, 0, 6'h3F);
    step(); idle();
    chk("t4_issue", bus.issuemult_enable, 1'b1);
    chk("t4_issue_rd", bus.issuemult_rdtag, 6'h20);
    chk("t4_issue_rs", bus.issuemult_rsdata, 32'h55);
    chk("t4_dropped_full", bus.issueque_full, 1'b0);
    bus.flush = 1'b1;
    step(); idle();
    chk("t4_flush_full", bus.issueque_full, 1'b0);
    drain();

    // 5: oldest ready first, the non-ready middle entry stays behind
    disp(1'b0, 0, 6'h11, 1'b1, 1, 0, 6'h0A); step();
    disp(1'b0, 0, 6'h22, 1'b1, 2, 0, 6'h0B); step();
    disp(1'b0, 0, 6'h11, 1'b1, 3, 0, 6'h0C); step();
    idle(); cdb(6'h11, 32'h44);
    step(); idle();
    chk("t5_wait", bus.issuemult_enable, 1'b0);
    step();
    chk("t5_first", bus.issuemult_rdtag, 6'h0A);
    chk("t5_first_en", bus.issuemult_enable, 1'b1);
    step();
    chk("t5_second", bus.issuemult_rdtag, 6'h0C);
    chk("t5_second_rt", bus.issuemult_rtdata, 3);
    step();
    chk("t5_idle", bus.issuemult_enable, 1'b0);
    cdb(6'h22, 32'h66);
    step(); idle();
    step();
    chk("t5_third", bus.issuemult_rdtag, 6'h0B);
    chk("t5_third_rs", bus.issuemult_rsdata, 32'h66);
    drain();

    // 6: flush with 3 resident entries and 2 products in flight, then reset
    disp(1'b1, 3, 0, 1'b1, 4, 0, 6'h01); step();
    disp(1'b1, 5, 0, 1'b1, 6, 0, 6'h02); step();
    for (int k = 0; k < 3; k++) begin
      disp(1'b0, 0, 6'h3A, 1'b1, 32'(k), 0, 6'(8'h03 + k));
      step();
    end
    idle(); bus.flush = 1'b1;
    step(); idle();
    for (int k = 0; k < int'(MULT_LAT) + 2; k++) begin
      chk("t6_no_issue", bus.issuemult_enable, 1'b0);
      chk("t6_no_done",  bus.mult_done_valid, 1'b0);
      chk("t6_not_full", bus.issueque_full, 1'b0);
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t6_rst_en", bus.issuemult_enable, 1'b0);
    chk("t6_rst_rs", bus.issuemult_rsdata, 0);
    chk("t6_rst_rt", bus.issuemult_rtdata, 0);
    chk("t6_rst_rd", bus.issuemult_rdtag, 0);
    chk("t6_rst_done", bus.mult_done_valid, 1'b0);
    chk("t6_rst_done_tag", bus.mult_done_rdtag, 0);
    chk("t6_rst_full", bus.issueque_full, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.dispatch_enable  = ($urandom_range(0, 3) != 0);
      bus.dispatch_rsvalid = 1'($urandom_range(0, 1));
      bus.dispatch_rsdata  = $urandom;
      bus.dispatch_rstag   = 6'($urandom_range(0, 7));
      bus.dispatch_rtvalid = 1'($urandom_range(0, 1));
      bus.dispatch_rtdata  = $urandom;
      bus.dispatch_rttag   = 6'($urandom_range(0, 7));
      bus.dispatch_rdtag   = 6'($urandom_range(0, 63));
      bus.cdb_valid        = ($urandom_range(0, 2) == 0);
      bus.cdb_tag          = 6'($urandom_range(0, 7));
      bus.cdb_data         = $urandom;
      bus.flush            = ($urandom_range(0, 99) == 0);
      reset                = ($urandom_range(0, 299) != 0);
      step();
    end
    reset = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
